// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: single-port framebuffer RAM arbiter.
// Display scan-out > clear sequencer > draw engine.
module fb_port_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 12,
  parameter int FB_WORDS  = 76800,
  parameter int STALL_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              drw_req,
  input  logic              drw_we,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [DATA_W-1:0] drw_wdata,
  output logic              drw_gnt,
  output logic              drw_rvalid,
  output logic [DATA_W-1:0] drw_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [7:0]        drw_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    T_NONE,
    T_DISP,
    T_DRW
  } tag_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FB_WORDS - 1);
  localparam logic [7:0] SMAX = 8'(STALL_MAX);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [ADDR_W-1:0] w_clr_ptr;
  logic [DATA_W-1:0] r_color;
  logic [DATA_W-1:0] w_color_nxt;
  logic [DATA_W-1:0] w_clr_col;
  logic              r_done;
  logic              w_done_nxt;

  logic w_clr_act;
  logic w_slot_disp;
  logic w_slot_clr;
  logic w_slot_drw;

  logic              w_en;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  tag_t              w_tag;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  tag_t              r_tag1;
  tag_t              r_tag2;
  logic [7:0]        r_stall;
  logic [7:0]        w_stall_nxt;

  // Slot decision, clear FSM next state and next RAM command.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_color_nxt = r_color;
    w_done_nxt  = 1'b0;
    w_en        = 1'b0;
    w_we        = 1'b0;
    w_addr      = r_mem_addr;
    w_wdata     = r_mem_wdata;
    w_tag       = T_NONE;

    // The clr_start cycle already owns the clear slot.
    w_clr_act = (r_state == S_CLEAR) || clr_start;
    w_clr_ptr = (r_state == S_IDLE) ? '0 : r_ptr;
    w_clr_col = (r_state == S_IDLE) ? clr_color
                                    : r_color;

    w_slot_disp = disp_req;
    w_slot_clr  = !disp_req && w_clr_act;
    w_slot_drw  = !disp_req && !w_clr_act
                  && drw_req;

    unique case (1'b1)
      w_slot_disp: begin
        w_en   = 1'b1;
        w_addr = disp_addr;
        w_tag  = T_DISP;
      end
      w_slot_clr: begin
        w_en    = 1'b1;
        w_we    = 1'b1;
        w_addr  = w_clr_ptr;
        w_wdata = w_clr_col;
      end
      w_slot_drw: begin
        w_en    = 1'b1;
        w_we    = drw_we;
        w_addr  = drw_addr;
        w_wdata = drw_wdata;
        w_tag   = drw_we ? T_NONE : T_DRW;
      end
      default: ;
    endcase

    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt = S_CLEAR;
          w_color_nxt = clr_color;
          w_ptr_nxt   = '0;
        end
      end
      S_CLEAR: ;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_slot_clr) begin
      if (w_clr_ptr == LAST) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
        w_ptr_nxt   = w_clr_ptr;
      end else begin
        w_ptr_nxt = w_clr_ptr + ADDR_W'(1);
      end
    end

    if (!drw_req || w_slot_drw)
      w_stall_nxt = '0;
    else if (r_stall == SMAX)
      w_stall_nxt = r_stall;
    else
      w_stall_nxt = r_stall + 8'd1;
  end

  // Clear FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_color <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_color <= w_color_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // RAM command, read tag pipe and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag1      <= T_NONE;
      r_tag2      <= T_NONE;
      r_stall     <= '0;
    end else begin
      r_mem_en    <= w_en;
      r_mem_we    <= w_we;
      r_mem_addr  <= w_addr;
      r_mem_wdata <= w_wdata;
      r_tag1      <= w_tag;
      r_tag2      <= r_tag1;
      r_stall     <= w_stall_nxt;
    end
  end

  assign drw_gnt     = w_slot_drw && !reset;
  assign disp_rvalid = (r_tag2 == T_DISP);
  assign drw_rvalid  = (r_tag2 == T_DRW);
  assign disp_rdata  = disp_rvalid ? mem_rdata
                                   : '0;
  assign drw_rdata   = drw_rvalid ? mem_rdata
                                  : '0;
  assign clr_busy    = (r_state == S_CLEAR);
  assign clr_done    = r_done;
  assign drw_stall   = r_stall;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: scoreboard bench for the
// framebuffer port arbiter with a behavioural RAM.
module tb_fb_port_arbiter;

  localparam int AW  = 17;
  localparam int DW  = 12;
  localparam int FBW = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          drw_req;
  logic          drw_we;
  logic [AW-1:0] drw_addr;
  logic [DW-1:0] drw_wdata;
  logic          drw_gnt;
  logic          drw_rvalid;
  logic [DW-1:0] drw_rdata;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic [7:0]    drw_stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .FB_WORDS(FBW),
    .STALL_MAX(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .disp_req(disp_req),
    .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid),
    .disp_rdata(disp_rdata),
    .drw_req(drw_req),
    .drw_we(drw_we),
    .drw_addr(drw_addr),
    .drw_wdata(drw_wdata),
    .drw_gnt(drw_gnt),
    .drw_rvalid(drw_rvalid),
    .drw_rdata(drw_rdata),
    .clr_start(clr_start),
    .clr_color(clr_color),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .drw_stall(drw_stall),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] pat(int a);
    return DW'((a * 37 + 5) & 'hFFF);
  endfunction

  // RAM model: preloaded pattern, 1-cycle read.
  logic [DW-1:0] ram [0:4095];
  bit            wr_ok [0:4095];
  logic [DW-1:0] rd_q;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[11:0]]   <= mem_wdata;
        wr_ok[mem_addr[11:0]] <= 1'b1;
      end else begin
        rd_q <= wr_ok[mem_addr[11:0]]
              ? ram[mem_addr[11:0]]
              : pat(int'(mem_addr[11:0]));
      end
    end
  end

  assign mem_rdata = rd_q;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t dq[$];
  exp_t wq[$];

  logic [DW-1:0] sh [0:4095];
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input int a);
    disp_req  = 1'b1;
    disp_addr = AW'(a);
    dq.push_back('{d: sh[a], due: cyc + 2});
  endtask

  task automatic drw_seen();
    if (drw_gnt && !drw_we)
      wq.push_back('{d: sh[drw_addr[11:0]],
                     due: cyc + 2});
  endtask

  task automatic drain();
    disp_req = 1'b0;
    repeat (4) tick();
    chk("dq_empty", dq.size(), 0);
    chk("wq_empty", wq.size(), 0);
  endtask

  // Read return monitor against the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (disp_rvalid) begin
        if (dq.size() == 0)
          chk("disp_extra", 1, 0);
        else begin
          e = dq.pop_front();
          chk("disp_lat", cyc, e.due);
          chk("disp_data", disp_rdata, e.d);
        end
      end else if (dq.size() != 0
                   && dq[0].due <= cyc) begin
        chk("disp_miss", 0, 1);
        void'(dq.pop_front());
      end
      if (drw_rvalid) begin
        if (wq.size() == 0)
          chk("drw_extra", 1, 0);
        else begin
          e = wq.pop_front();
          chk("drw_lat", cyc, e.due);
          chk("drw_data", drw_rdata, e.d);
        end
      end else if (wq.size() != 0
                   && wq[0].due <= cyc) begin
        chk("drw_miss", 0, 1);
        void'(wq.pop_front());
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, mem_en, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, clr_busy, 0);
    chk({tag, "_done"}, clr_done, 0);
    chk({tag, "_stall"}, drw_stall, 0);
    chk({tag, "_gnt"}, drw_gnt, 0);
    chk({tag, "_dval"}, disp_rvalid, 0);
    chk({tag, "_wval"}, drw_rvalid, 0);
    chk({tag, "_drd"}, disp_rdata, 0);
    chk({tag, "_wrd"}, drw_rdata, 0);
  endtask

  task automatic wait_done(input int lim,
                           output bit got,
                           output int at,
                           output bit bad_gnt);
    got     = 1'b0;
    at      = 0;
    bad_gnt = 1'b0;
    for (int k = 0; k < lim && !got; k++) begin
      @(negedge clk);
      if (clr_busy && drw_gnt) bad_gnt = 1'b1;
      if (clr_done) begin
        got = 1'b1;
        at  = cyc;
      end
    end
  endtask

  initial begin : stim
    int s;
    int at;
    bit got;
    bit bad;
    bit ph;
    reset     = 1'b1;
    disp_req  = 1'b0;
    disp_addr = '0;
    drw_req   = 1'b0;
    drw_we    = 1'b0;
    drw_addr  = '0;
    drw_wdata = '0;
    clr_start = 1'b0;
    clr_color = '0;
    for (int i = 0; i < 4096; i++) sh[i] = pat(i);

    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    reset = 1'b0;

    // display only, continuous
    for (int i = 0; i < 10; i++) begin
      tick();
      drive_disp(i);
      if (i > 0) begin
        chk("disp_en", mem_en, 1);
        chk("disp_we", mem_we, 0);
        chk("disp_addr", mem_addr, i - 1);
      end
    end
    tick();
    disp_req = 1'b0;
    chk("disp_addr9", mem_addr, 9);
    drain();

    // draw write then read back
    tick();
    drw_req   = 1'b1;
    drw_we    = 1'b1;
    drw_addr  = AW'(100);
    drw_wdata = 12'hF0A;
    @(negedge clk);
    chk("wr_gnt", drw_gnt, 1);
    sh[100] = 12'hF0A;
    tick();
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 100);
    chk("wr_mem_data", mem_wdata, 'hF0A);
    drw_we = 1'b0;
    @(negedge clk);
    chk("rd_gnt", drw_gnt, 1);
    drw_seen();
    tick();
    drw_req = 1'b0;
    drain();

    // contention: 5 display cycles vs draw
    tick();
    drw_req  = 1'b1;
    drw_we   = 1'b0;
    drw_addr = AW'(200);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      drive_disp(2048 + k);
      @(negedge clk);
      chk("cont_gnt", drw_gnt, 0);
    end
    tick();
    disp_req = 1'b0;
    chk("cont_stall", drw_stall, 5);
    @(negedge clk);
    chk("cont_gnt_rel", drw_gnt, 1);
    drw_seen();
    tick();
    drw_req = 1'b0;
    chk("cont_stall_clr", drw_stall, 0);
    drain();

    // stall saturation
    tick();
    drw_req  = 1'b1;
    drw_addr = AW'(300);
    for (int k = 0; k < 300; k++) begin
      if (k > 0) tick();
      drive_disp(2048 + (k % 100));
      if (k == 200) chk("sat_mid", drw_stall, 200);
    end
    tick();
    chk("sat_stall", drw_stall, 255);
    disp_req = 1'b0;
    @(negedge clk);
    chk("sat_gnt", drw_gnt, 1);
    drw_seen();
    tick();
    drw_req = 1'b0;
    drain();

    // clear with a draw write pending
    tick();
    clr_color = 12'h123;
    clr_start = 1'b1;
    drw_req   = 1'b1;
    drw_we    = 1'b1;
    drw_addr  = AW'(50);
    drw_wdata = 12'h777;
    s = cyc;
    @(negedge clk);
    chk("clr_start_gnt", drw_gnt, 0);
    tick();
    clr_start = 1'b0;
    clr_color = 12'h000;
    chk("clr_busy", clr_busy, 1);
    chk("clr_first_we", mem_we, 1);
    chk("clr_first_addr", mem_addr, 0);
    chk("clr_first_data", mem_wdata, 'h123);
    wait_done(FBW + 20, got, at, bad);
    chk("clr_done_seen", got, 1);
    chk("clr_len", at - s, FBW);
    chk("clr_gnt_busy", bad, 0);
    chk("clr_busy_end", clr_busy, 0);
    chk("clr_gnt_after", drw_gnt, 1);
    for (int i = 0; i < FBW; i++) sh[i] = 12'h123;
    sh[50] = 12'h777;
    tick();
    drw_req = 1'b0;
    for (int a = 0; a < FBW; a++) begin
      tick();
      drive_disp(a);
    end
    tick();
    drain();

    // clear with display every other cycle
    tick();
    clr_color = 12'h3C5;
    clr_start = 1'b1;
    s   = cyc;
    got = 1'b0;
    ph  = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 2 * FBW + 20 && !got; k++) begin
      if (ph) drive_disp(2048 + (k % 512));
      else disp_req = 1'b0;
      @(negedge clk);
      if (clr_done) begin
        got = 1'b1;
        at  = cyc;
      end
      ph = !ph;
      tick();
    end
    disp_req = 1'b0;
    chk("alt_done_seen", got, 1);
    chk("alt_len", at - s, 2 * FBW - 1);
    for (int i = 0; i < FBW; i++) sh[i] = 12'h3C5;
    tick();
    drive_disp(0);
    tick();
    drive_disp(1000);
    tick();
    drive_disp(FBW - 1);
    tick();
    drain();

    // reset in the middle of a clear
    tick();
    clr_color = 12'h0AA;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (999) tick();
    chk("mid_ptr", mem_addr, 999);
    reset = 1'b1;
    #1;
    chk_zero("mid_rst");
    tick();
    tick();
    reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < FBW + 10; k++) begin
      @(negedge clk);
      if (clr_done || clr_busy) bad = 1'b1;
    end
    chk("mid_no_done", bad, 0);
    tick();
    clr_color = 12'h0BB;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("restart_we", mem_we, 1);
    chk("restart_addr", mem_addr, 0);
    chk("restart_data", mem_wdata, 'h0BB);
    wait_done(FBW + 20, got, at, bad);
    chk("restart_done", got, 1);
    for (int i = 0; i < FBW; i++) sh[i] = 12'h0BB;
    tick();
    drive_disp(0);
    tick();
    drive_disp(999);
    tick();
    drive_disp(1000);
    tick();
    drive_disp(FBW - 1);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
